async_fifo_2: RTL and testbench
===============================

Name: async_fifo_2

Overview:
Dual-clock FIFO that carries DATESIZE-bit words from a write clock domain (wclk) to an independent read clock domain (rclk).
- Storage depth is 2^ADDRSIZE words.
- Full/empty detection uses Gray-coded pointers (ADDRSIZE+1 bits) with two-flop synchronizers between the domains.
- Used at clock-domain crossings where producer and consumer clocks are unrelated in frequency and phase.

Parameters:
DATESIZE  8  data word width in bits
ADDRSIZE  3  address width; depth DEPTH = 2^ADDRSIZE (8)

Ports:
wclk    input   1         write-domain clock
w_rstn  input   1         write-domain reset
rclk    input   1         read-domain clock
r_rstn  input   1         read-domain reset
wdata   input   DATESIZE  write data, sampled at wclk rising edge when winc=1 and wfull=0
winc    input   1         write request
rinc    input   1         read request, sampled at rclk rising edge
rdata   output  DATESIZE  read data: word at the current read address
wfull   output  1         FIFO full (wclk domain, registered)
rempty  output  1         FIFO empty (rclk domain, registered)

Clocking and reset:
- Each domain runs on one clock: wclk for write-side logic, rclk for read-side logic.
- Reset is asynchronous and active-low: w_rstn for the write domain, r_rstn for the read domain.

Behaviour:
- Reset
  - w_rstn=0: clears wbin, wptr (Gray), the write-side copy of the read pointer and its sync stage; wfull=0.
  - r_rstn=0: clears rbin, rptr, the read-side copy of the write pointer and its sync stage; rempty=1.
  - Memory is not reset.
- Write
  - On wclk posedge with winc & ~wfull: mem[wbin[ADDRSIZE-1:0]] <= wdata; wbin += 1.
  - wptr = wbin_next ^ (wbin_next >> 1), registered.
  - winc while wfull: ignored. No write occurs and no pointer change.
- Read
  - rdata = mem[rbin[ADDRSIZE-1:0]], combinational (show-ahead); the word is valid whenever rempty=0.
  - On rclk posedge with rinc & ~rempty: rbin += 1 and rptr is updated to the Gray code of the new value.
  - rinc while rempty: ignored.
- Synchronizers
  - rptr passes through 2 wclk flops to produce wq2_rptr.
  - wptr passes through 2 rclk flops to produce rq2_wptr.
  - Only Gray-coded values cross domains.
- Flags (registered, computed from next-pointer values)
  - rempty <= (rgray_next == rq2_wptr).
  - wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - The wrap bit distinguishes full from empty.
- Latency
  - Write to rempty deassertion: 2-3 rclk edges.
  - Read to wfull deassertion: 2-3 wclk edges.
  - Flags are pessimistic: they may stay asserted longer than needed but never assert late. No overflow or underflow is possible.
- Wrap-around: pointers wrap naturally modulo 2^(ADDRSIZE+1).
- Simultaneous read and write in the same cycle (non-full, non-empty): both take effect; occupancy is unchanged.
- Reset mid-operation: resetting a single domain is only supported when the other domain is idle; the FIFO contents are then considered lost.

Optional Feature:
ASYNC_FIFO_2_ALMOST_EN
- When defined: adds output walmost_full (wclk domain, registered), asserted when the write-side occupancy (wbin - Gray-to-binary of wq2_rptr) is ≥ DEPTH-1.
- When defined: adds output ralmost_empty (rclk domain, registered), asserted when the read-side occupancy is ≤ 1. Both reset to walmost_full=0 and ralmost_empty=1.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package async_fifo_2_pkg:
  - Default DATESIZE and ADDRSIZE.
  - DEPTH localparam.
  - bin2gray function; gray2bin function (used only when ASYNC_FIFO_2_ALMOST_EN is defined).
- Sub-module async_fifo_2_sync: a parameterised-width 2-flop synchronizer with async active-low reset, instantiated once per direction.
- Memory, write-pointer/full logic and read-pointer/empty logic stay in the top module.

Test Plan:
- Reset: hold both resets low, then release -> wfull=0, rempty=1; no pointer movement while winc=rinc=0.
- Fill (wclk period 2, rclk period 8): winc=1 with wdata=0,1,2,... each wclk, rinc=0 -> exactly 8 words stored (0..7); wfull=1 after the 8th write; further data (8, 9, ...) is dropped.
- Drain: winc=0, rinc=1 -> rdata sequence 0..7 in order; rempty=1 after the 8th read; wfull drops within 3 wclk edges of the first read.
- Empty read: rinc=1 while rempty=1 for 10 rclk cycles -> rbin unchanged; no rdata change; rempty stays 1.
- Concurrent streaming: winc=1 and rinc=1 with writes faster than reads -> the read stream is a strictly increasing, gap-free subsequence of accepted writes; wfull toggles; no word is lost once accepted and none is duplicated.
- Wrap: perform 20 write/read pairs one at a time -> data intact across pointer wrap; rempty=1 at the end.

Source files
------------

// File: rtl/async_fifo_2_pkg.sv
// Shared definitions for the async_fifo_2 dual-clock FIFO: default sizes and
// Gray/binary pointer conversion helpers.
package async_fifo_2_pkg;

  // Default data width and address width; depth is 2^ADDRSIZE.
  localparam int unsigned DEF_DATESIZE = 8;
  localparam int unsigned DEF_ADDRSIZE = 3;
  localparam int unsigned DEPTH        = 1 << DEF_ADDRSIZE;

  // Helpers work on a wide container; callers size-cast the result back down.
  localparam int unsigned PTR_MAXW = 32;

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended Gray input decodes correctly since the extra top bits are zero.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] gray);
    logic [PTR_MAXW-1:0] bin;
    bin[PTR_MAXW-1] = gray[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_2_sync.sv
// Two-flop synchronizer carrying a Gray-coded pointer into the i_clk domain.
module async_fifo_2_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  // First stage may go metastable; only the second stage is consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/async_fifo_2.sv
// Dual-clock FIFO: DATESIZE-bit words from wclk domain to rclk domain, depth 2^ADDRSIZE.
// Full/empty use Gray pointers (ADDRSIZE+1 bits, extra wrap bit) crossed by 2-flop syncs.
// Optional macro ASYNC_FIFO_2_ALMOST_EN adds walmost_full / ralmost_empty outputs.
module async_fifo_2
  import async_fifo_2_pkg::*;
#(
  parameter int unsigned DATESIZE = DEF_DATESIZE,
  parameter int unsigned ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                wclk,
  input  logic                w_rstn,
  input  logic                rclk,
  input  logic                r_rstn,
  input  logic [DATESIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  output logic [DATESIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty
`ifdef ASYNC_FIFO_2_ALMOST_EN
  ,
  output logic                walmost_full,
  output logic                ralmost_empty
`endif
);

  localparam int unsigned PW = ADDRSIZE + 1;

  // Storage is intentionally not reset.
  logic [DATESIZE-1:0] r_mem [(1 << ADDRSIZE)];

  // Write domain
  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr;
  logic              r_wfull;
  logic [ADDRSIZE:0] w_wbin_next;
  logic [ADDRSIZE:0] w_wgray_next;
  logic [ADDRSIZE:0] w_wq2_rptr;
  logic              w_wen;
  logic              w_wfull_next;

  // Read domain
  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic [ADDRSIZE:0] w_rbin_next;
  logic [ADDRSIZE:0] w_rgray_next;
  logic [ADDRSIZE:0] w_rq2_wptr;
  logic              w_ren;
  logic              w_rempty_next;

  // ---------------------------------------------------------------- write side
  assign w_wen        = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{ADDRSIZE{1'b0}}, w_wen};
  assign w_wgray_next = PW'(bin2gray(PTR_MAXW'(w_wbin_next)));
  // Full when next write pointer has lapped the read pointer: top two Gray bits inverted.
  assign w_wfull_next = (w_wgray_next ==
                         {~w_wq2_rptr[ADDRSIZE -: 2], w_wq2_rptr[ADDRSIZE-2:0]});

  // Write pointer (binary + Gray) and registered full flag.
  always_ff @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_wfull <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_wfull <= w_wfull_next;
    end
  end

  // Memory write port, gated so a write while full never lands.
  always_ff @(posedge wclk) begin
    if (w_wen) begin
      r_mem[r_wbin[ADDRSIZE-1:0]] <= wdata;
    end
  end

  // ----------------------------------------------------------------- read side
  assign w_ren         = rinc & ~r_rempty;
  assign w_rbin_next   = r_rbin + {{ADDRSIZE{1'b0}}, w_ren};
  assign w_rgray_next  = PW'(bin2gray(PTR_MAXW'(w_rbin_next)));
  assign w_rempty_next = (w_rgray_next == w_rq2_wptr);

  // Read pointer (binary + Gray) and registered empty flag.
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbin_next;
      r_rptr   <= w_rgray_next;
      r_rempty <= w_rempty_next;
    end
  end

  // Show-ahead: head word is presented without waiting for rinc.
  assign rdata  = r_mem[r_rbin[ADDRSIZE-1:0]];
  assign wfull  = r_wfull;
  assign rempty = r_rempty;

  // ----------------------------------------------------------- synchronizers
  async_fifo_2_sync #(
    .Width(PW)
  ) u_sync_r2w (
    .i_clk  (wclk),
    .i_rst_n(w_rstn),
    .i_d    (r_rptr),
    .o_q    (w_wq2_rptr)
  );

  async_fifo_2_sync #(
    .Width(PW)
  ) u_sync_w2r (
    .i_clk  (rclk),
    .i_rst_n(r_rstn),
    .i_d    (r_wptr),
    .o_q    (w_rq2_wptr)
  );

`ifdef ASYNC_FIFO_2_ALMOST_EN
  localparam int unsigned FIFO_DEPTH = 1 << ADDRSIZE;

  logic [ADDRSIZE:0] w_wocc_next;
  logic [ADDRSIZE:0] w_rocc_next;
  logic              r_walmost_full;
  logic              r_ralmost_empty;

  // Occupancy as seen from each side; modulo arithmetic handles pointer wrap.
  assign w_wocc_next = w_wbin_next - PW'(gray2bin(PTR_MAXW'(w_wq2_rptr)));
  assign w_rocc_next = PW'(gray2bin(PTR_MAXW'(w_rq2_wptr))) - w_rbin_next;

  // Almost-full flag in the write domain.
  always_ff @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_walmost_full <= 1'b0;
    end else begin
      r_walmost_full <= (w_wocc_next >= PW'(FIFO_DEPTH - 1));
    end
  end

  // Almost-empty flag in the read domain.
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_ralmost_empty <= 1'b1;
    end else begin
      r_ralmost_empty <= (w_rocc_next <= PW'(1));
    end
  end

  assign walmost_full  = r_walmost_full;
  assign ralmost_empty = r_ralmost_empty;
`endif

endmodule

// File: tb/tb_async_fifo_2.sv
// Self-checking bench for async_fifo_2: table-driven fill/drain, hand-written corner
// sequences, and a randomized two-clock stream checked against a queue model.
`timescale 1ns/1ps
module tb_async_fifo_2;

  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 3;
  localparam int unsigned DEPTH_TB = 8;

  logic          wclk   = 1'b0;
  logic          rclk   = 1'b0;
  logic          w_rstn = 1'b1;
  logic          r_rstn = 1'b1;
  logic [DW-1:0] wdata  = '0;
  logic          winc   = 1'b0;
  logic          rinc   = 1'b0;
  logic [DW-1:0] rdata;
  logic          wfull;
  logic          rempty;
`ifdef ASYNC_FIFO_2_ALMOST_EN
  logic          walmost_full;
  logic          ralmost_empty;
`endif

  // wclk posedges at odd ns, rclk posedges at 4 mod 8: the two never coincide.
  always #1 wclk = ~wclk;
  always #4 rclk = ~rclk;

  async_fifo_2 #(
    .DATESIZE(DW),
    .ADDRSIZE(AW)
  ) dut (
    .wclk  (wclk),
    .w_rstn(w_rstn),
    .rclk  (rclk),
    .r_rstn(r_rstn),
    .wdata (wdata),
    .winc  (winc),
    .rinc  (rinc),
    .rdata (rdata),
    .wfull (wfull),
    .rempty(rempty)
`ifdef ASYNC_FIFO_2_ALMOST_EN
    ,
    .walmost_full (walmost_full),
    .ralmost_empty(ralmost_empty)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the words the FIFO should hold, oldest first.
  logic [DW-1:0] model_q[$];

  typedef struct {
    logic          winc;
    logic [DW-1:0] wdata;
    logic          exp_wfull;
  } wvec_t;

  typedef struct {
    logic          rinc;
    logic [DW-1:0] exp_rdata;
    logic          exp_rempty;
  } rvec_t;

  wvec_t fill_tbl [12];
  rvec_t drain_tbl [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Bounded wait (in rclk cycles) for rempty to reach a value; a timeout is a failure.
  task automatic wait_rempty(input logic val, input string name);
    for (int k = 0; k < 20 && rempty !== val; k++) @(negedge rclk);
    check(name, rempty, val);
  endtask

  task automatic do_reset();
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    w_rstn = 1'b1;
    r_rstn = 1'b1;
    #1;
    w_rstn = 1'b0;
    r_rstn = 1'b0;
    #20;
    @(negedge wclk) w_rstn = 1'b1;
    @(negedge rclk) r_rstn = 1'b1;
    model_q.delete();
    @(negedge rclk);
    check("reset_wfull", wfull, 0);
    check("reset_rempty", rempty, 1);
  endtask

  // Streaming-phase state shared by the writer and reader processes.
  logic stream_wr_done;
  int   full_rise;
  int   full_fall;

  initial begin
    // Fill: 12 attempts, only the first 8 land; full rises on the 8th write.
    for (int i = 0; i < 12; i++) fill_tbl[i] = '{1'b1, DW'(i), (i >= 7)};
    // Drain: 0..7 in order; empty rises on the 8th read.
    for (int j = 0; j < 8; j++) drain_tbl[j] = '{1'b1, DW'(j), (j == 7)};

    do_reset();

    // Idle: no movement with winc = rinc = 0.
    repeat (5) @(negedge rclk);
    check("idle_wfull", wfull, 0);
    check("idle_rempty", rempty, 1);

    // ---------------------------------------------------------------- fill
    @(negedge wclk);
    for (int i = 0; i < 12; i++) begin
      winc  = fill_tbl[i].winc;
      wdata = fill_tbl[i].wdata;
      if (winc && !wfull) model_q.push_back(wdata);
      @(negedge wclk);
      check("fill_wfull", wfull, fill_tbl[i].exp_wfull);
    end
    winc = 1'b0;

    // ---------------------------------------------------------------- drain
    @(negedge rclk);
    wait_rempty(0, "fill_visible");
    for (int j = 0; j < 8; j++) begin
      check("drain_rdata", rdata, drain_tbl[j].exp_rdata);
      rinc = drain_tbl[j].rinc;
      void'(model_q.pop_front());
      if (j == 0) begin
        // Full must release within 3 wclk edges of the first read.
        fork
          begin
            @(posedge rclk);
            repeat (3) @(posedge wclk);
            @(negedge wclk);
            check("wfull_release", wfull, 0);
          end
        join_none
      end
      @(negedge rclk);
      check("drain_rempty", rempty, drain_tbl[j].exp_rempty);
    end

    // ------------------------------------------------------- read while empty
    // rinc stays high; pointer must not move, head address stays at slot 0 (holds 0).
    for (int k = 0; k < 10; k++) begin
      @(negedge rclk);
      check("empty_read_rempty", rempty, 1);
      check("empty_read_rdata", rdata, 0);
    end
    rinc = 1'b0;

    // A fresh word must appear at the head, proving the read pointer stayed put.
    @(negedge wclk);
    check("pre_write_wfull", wfull, 0);
    winc  = 1'b1;
    wdata = 8'hA5;
    model_q.push_back(wdata);
    @(negedge wclk);
    winc = 1'b0;
    @(negedge rclk);
    wait_rempty(0, "a5_visible");
    check("a5_rdata", rdata, model_q[0]);
    rinc = 1'b1;
    void'(model_q.pop_front());
    @(negedge rclk);
    rinc = 1'b0;
    check("a5_empty_after", rempty, 1);

    // ---------------------------------------------------------------- wrap
    for (int k = 0; k < 20; k++) begin
      logic [DW-1:0] exp_d;
      @(negedge wclk);
      winc  = 1'b1;
      wdata = DW'($urandom);
      model_q.push_back(wdata);
      @(negedge wclk);
      winc = 1'b0;
      @(negedge rclk);
      wait_rempty(0, "wrap_visible");
      exp_d = model_q.pop_front();
      check("wrap_rdata", rdata, exp_d);
      rinc = 1'b1;
      @(negedge rclk);
      rinc = 1'b0;
      check("wrap_empty", rempty, 1);
    end

    // ---------------------------------------------------- random streaming
    stream_wr_done = 1'b0;
    full_rise      = 0;
    full_fall      = 0;
    fork
      begin : writer
        logic prev_full;
        prev_full = wfull;
        for (int c = 0; c < 400; c++) begin
          @(negedge wclk);
          if (wfull && !prev_full) full_rise++;
          if (!wfull && prev_full) full_fall++;
          prev_full = wfull;
          // Full deasserted means genuine room: the model must not already be at depth.
          if (!wfull) check("stream_no_overflow", (model_q.size() < DEPTH_TB), 1);
          winc  = $urandom_range(0, 1) == 1;
          wdata = DW'($urandom);
          if (winc && !wfull) model_q.push_back(wdata);
        end
        @(negedge wclk);
        winc           = 1'b0;
        stream_wr_done = 1'b1;
      end
      begin : reader
        int cyc;
        cyc = 0;
        while (!(stream_wr_done && model_q.size() == 0) && cyc < 1000) begin
          @(negedge rclk);
          cyc++;
          if (!rempty) begin
            if (model_q.size() == 0) check("stream_underflow", 1, 0);
            else check("stream_rdata", rdata, model_q[0]);
          end
          rinc = $urandom_range(0, 9) < 8;
          if (rinc && !rempty) void'(model_q.pop_front());
        end
        @(negedge rclk);
        rinc = 1'b0;
      end
    join
    check("stream_drained", model_q.size(), 0);
    check("stream_full_seen", (full_rise > 0), 1);
    check("stream_full_released", (full_fall > 0), 1);
    wait_rempty(1, "stream_end_empty");

    // Reset again after activity: flags return to their reset values.
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
